imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction RAM: length header, then LE words.
// Ports: clk/rst_n, start/abort, in_valid/in_ready/in_data, wr_*, busy/done/err.
module imem_loader #(
  parameter int DEPTH = 10240,
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_index,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    LAST,
    DN,
    ER
  } state_t;

  state_t           state, state_n;
  logic [31:0]      len, len_n;
  logic [31:0]      word, word_n;
  logic [IDX_W:0]   word_cnt, word_cnt_n;
  logic [1:0]       byte_cnt, byte_cnt_n;
  logic             in_ready_n;
  logic             wr_en_n;
  logic [IDX_W-1:0] wr_index_n;
  logic [31:0]      wr_data_n;
  logic             busy_n;
  logic             done_n;
  logic             err_n;

  logic             fire;
  logic [31:0]      len_full;
  logic [31:0]      word_full;

  assign fire      = in_valid && in_ready;
  // Shift-right insertion leaves byte k at [8k+7:8k] after four bytes.
  assign len_full  = {in_data, len[31:8]};
  assign word_full = {in_data, word[31:8]};

  always_comb begin
    state_n    = state;
    len_n      = len;
    word_n     = word;
    word_cnt_n = word_cnt;
    byte_cnt_n = byte_cnt;
    in_ready_n = in_ready;
    wr_en_n    = 1'b0;
    wr_index_n = wr_index;
    wr_data_n  = wr_data;
    busy_n     = busy;
    done_n     = done;
    err_n      = err;
    if (abort) begin
      state_n    = IDLE;
      in_ready_n = 1'b0;
      busy_n     = 1'b0;
      done_n     = 1'b0;
      err_n      = 1'b0;
      byte_cnt_n = 2'd0;
    end else begin
      unique case (state)
        IDLE, DN, ER: begin
          if (start) begin
            state_n    = LEN;
            len_n      = 32'd0;
            byte_cnt_n = 2'd0;
            word_cnt_n = '0;
            done_n     = 1'b0;
            err_n      = 1'b0;
            busy_n     = 1'b1;
            in_ready_n = 1'b1;
          end
        end
        LEN: begin
          if (fire) begin
            len_n      = len_full;
            byte_cnt_n = byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (len_full == 32'd0 ||
                  len_full > 32'(DEPTH)) begin
                state_n    = ER;
                err_n      = 1'b1;
                busy_n     = 1'b0;
                in_ready_n = 1'b0;
              end else begin
                state_n = DATA;
              end
            end
          end
        end
        DATA: begin
          if (fire) begin
            word_n     = word_full;
            byte_cnt_n = byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en_n    = 1'b1;
              wr_data_n  = word_full;
              wr_index_n = word_cnt[IDX_W-1:0];
              word_cnt_n = word_cnt + 1'b1;
              // Stop accepting on the same edge the last write issues.
              if (32'(word_cnt) == len - 32'd1) begin
                state_n    = LAST;
                in_ready_n = 1'b0;
              end
            end
          end
        end
        LAST: begin
          state_n = DN;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      word     <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_index <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      word     <= word_n;
      word_cnt <= word_cnt_n;
      byte_cnt <= byte_cnt_n;
      in_ready <= in_ready_n;
      wr_en    <= wr_en_n;
      wr_index <= wr_index_n;
      wr_data  <= wr_data_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random streams vs. a word-level model.
// Driver works on negedges, monitor samples 1ns after each posedge.
module tb_imem_loader;

  localparam int DEPTH = 10240;
  localparam int IDX_W = 14;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             start = 0;
  logic             abort = 0;
  logic             in_valid = 0;
  logic [7:0]       in_data = 0;
  logic             in_ready;
  logic             wr_en;
  logic [IDX_W-1:0] wr_index;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             err;

  imem_loader #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] words[$];
  int          checks = 0;
  int          failures = 0;
  bit          chk_done_next = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write strobe.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (chk_done_next) begin
      chk_done_next = 0;
      chk("done_after_last", {31'd0, done}, 32'd1);
      chk("busy_after_last", {31'd0, busy}, 32'd0);
    end
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=idx %0d data %h required=none",
                 wr_index, wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_index", 32'(wr_index), 32'(e.idx));
        chk("wr_data", wr_data, e.data);
        if (e.last) begin
          chk("in_ready_at_last", {31'd0, in_ready}, 32'd0);
          chk("done_low_at_last", {31'd0, done}, 32'd0);
          chk_done_next = 1;
        end
      end
    end
  end

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic send(input logic [7:0] b[$], input int gap);
    int  i = 0;
    int  guard = 0;
    bit  pend = 0;
    while (i < b.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (!pend) begin
        if ($urandom_range(99) < gap) begin
          in_valid = 0;
        end else begin
          in_valid = 1;
          in_data  = b[i];
          pend     = 1;
        end
      end
      if (pend && in_ready) begin
        i++;
        pend = 0;
      end
    end
    if (i < b.size()) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout actual=%0d bytes required=%0d", i, b.size());
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ready", {31'd0, in_ready}, 32'd1);
    chk("start_err_clr", {31'd0, err}, 32'd0);
    chk("start_done_clr", {31'd0, done}, 32'd0);
  endtask

  // Model: header N, then N words from 'words'; only complete words within
  // 'limit' bytes are expected to be written. Bad N means no writes.
  task automatic run_load(input logic [31:0] n, input int limit,
                          input int gap);
    logic [7:0] b[$];
    bit         ok;
    int         total;
    logic [31:0] w;
    ok = (n != 0) && (n <= 32'(DEPTH));
    for (int k = 0; k < 4; k++) b.push_back(8'(n >> (8 * k)));
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        w = words[i];
        for (int k = 0; k < 4; k++) b.push_back(8'(w >> (8 * k)));
        if (4 + 4 * (i + 1) <= limit)
          sb.push_back('{idx: i, data: w, last: (i == int'(n) - 1)});
      end
    end
    total = b.size();
    while (b.size() > limit) void'(b.pop_back());
    pulse_start();
    send(b, gap);
    if (!ok) begin
      repeat (2) @(negedge clk);
      chk("bad_len_err", {31'd0, err}, 32'd1);
      chk("bad_len_ready", {31'd0, in_ready}, 32'd0);
      chk("bad_len_busy", {31'd0, busy}, 32'd0);
    end else if (limit >= total) begin
      for (int t = 0; t < 20 && !done; t++) @(negedge clk);
      chk("load_done", {31'd0, done}, 32'd1);
      chk("load_busy", {31'd0, busy}, 32'd0);
      chk("load_ready", {31'd0, in_ready}, 32'd0);
    end else begin
      for (int t = 0; t < 4 && sb.size() != 0; t++) @(negedge clk);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_index", 32'(wr_index), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    words = '{32'h0000_0013, 32'h0010_0093};
    run_load(2, 1000, 0);

    for (int r = 0; r < 3; r++) run_load(2, 1000, 50);

    run_load(0, 1000, 0);
    run_load(32'd10241, 1000, 20);
    run_load(32'h0100_0000, 1000, 0);

    fill_random(3);
    run_load(3, 1000, 30);

    fill_random(2);
    run_load(2, 6, 0);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    words = '{32'hDEAD_BEEF};
    run_load(1, 1000, 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(8, 1);
      fill_random(n);
      run_load(n, 1000, $urandom_range(60));
    end

    fill_random(5);
    run_load(5, 16, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    fill_random(2);
    run_load(2, 1000, 10);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
